// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage types and sizes: physical/architectural register widths
// and free-list geometry, used by the rename map, ROB, issue logic and free list.
package phys_free_list_pkg;

    localparam int PREG_W    = 6;
    localparam int AREG_W    = 5;
    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int CNT_W     = $clog2(FL_DEPTH + 1);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

endpackage

// File: rtl/phys_free_list_if.sv
// Rename-stage <-> free-list signal bundle. The rename/retire side is the
// master; the free list itself is the slave.
interface phys_free_list_if
    import phys_free_list_pkg::*;
();

    logic             stall;
    logic             alloc_req;
    logic             alloc_valid;
    preg_t            alloc_preg;
    logic             retire_valid;
    preg_t            retire_old_preg;
    logic             recover;
    logic [CNT_W-1:0] count;
    logic             error;

    modport master (
        output stall, alloc_req, retire_valid, retire_old_preg, recover,
        input  alloc_valid, alloc_preg, count, error
    );

    modport slave (
        input  stall, alloc_req, retire_valid, retire_old_preg, recover,
        output alloc_valid, alloc_preg, count, error
    );

endinterface

// File: rtl/phys_free_list_ram.sv
// Free-list entry storage: one asynchronous read port (head), one synchronous
// write port (tail); reset reloads the initial free registers AREGS+i.
module free_list_ram
    import phys_free_list_pkg::*;
#(
    parameter int AREGS = NUM_AREGS,
    parameter int DEPTH = FL_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  preg_t            wdata,
    input  logic [PTR_W-1:0] raddr,
    output preg_t            rdata
);

    preg_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(AREGS + i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/phys_free_list.sv
// Physical-register free list for rename: allocates from head, refills from
// retire at tail, and rolls head back to the committed position on mispredict.
module phys_free_list
    import phys_free_list_pkg::*;
#(
    parameter int PREGS = NUM_PREGS,
    parameter int AREGS = NUM_AREGS,
    parameter int DEPTH = PREGS - AREGS
) (
    input  logic clk,
    input  logic reset,
    phys_free_list_if.slave fl
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   cnt_wide_t;

    localparam ptr_t      PTR_LAST   = ptr_t'(DEPTH - 1);
    localparam cnt_t      DEPTH_C    = cnt_t'(DEPTH);
    localparam cnt_wide_t DEPTH_WIDE = cnt_wide_t'(DEPTH);

    ptr_t  head_q, tail_q, commit_head_q;
    ptr_t  head_d, tail_d, commit_head_d;
    cnt_t  count_q, spec_used_q;
    cnt_t  count_d, spec_used_d;
    cnt_t  count_after_ret, spec_after_ret;
    logic  error_q;
    logic  alloc_valid, alloc_fire;
    logic  retire_ok, retire_commit, proto_err;
    preg_t head_preg;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Recovery sums can only exceed DEPTH after an orphan retire has already
    // flagged error; clamp so count never reports more than the buffer holds.
    function automatic cnt_t sat_count(input cnt_wide_t v);
        return (v > DEPTH_WIDE) ? DEPTH_C : cnt_t'(v);
    endfunction

    free_list_ram #(
        .AREGS (AREGS),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (retire_ok),
        .waddr (tail_q),
        .wdata (fl.retire_old_preg),
        .raddr (head_q),
        .rdata (head_preg)
    );

    assign alloc_valid = (count_q != '0);

    always_comb begin
        alloc_fire    = fl.alloc_req && alloc_valid && !fl.stall && !fl.recover;
        retire_ok     = fl.retire_valid && (count_q != DEPTH_C);
        retire_commit = retire_ok && (spec_used_q != '0);
        // Covers both a retire into a full list and a retire with nothing in flight.
        proto_err     = fl.retire_valid && !retire_commit;

        tail_d          = retire_ok ? ptr_inc(tail_q) : tail_q;
        commit_head_d   = retire_commit ? ptr_inc(commit_head_q) : commit_head_q;
        count_after_ret = count_q + cnt_t'(retire_ok);
        spec_after_ret  = spec_used_q - cnt_t'(retire_commit);

        if (fl.recover) begin
            head_d      = commit_head_d;
            count_d     = sat_count({1'b0, count_after_ret} + {1'b0, spec_after_ret});
            spec_used_d = '0;
        end else begin
            head_d      = alloc_fire ? ptr_inc(head_q) : head_q;
            count_d     = count_after_ret - cnt_t'(alloc_fire);
            spec_used_d = spec_after_ret + cnt_t'(alloc_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            commit_head_q <= '0;
            count_q       <= DEPTH_C;
            spec_used_q   <= '0;
            error_q       <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            commit_head_q <= commit_head_d;
            count_q       <= count_d;
            spec_used_q   <= spec_used_d;
            error_q       <= error_q | proto_err;
        end
    end

    assign fl.alloc_valid = alloc_valid;
    assign fl.alloc_preg  = head_preg;
    assign fl.count       = count_q;
    assign fl.error       = error_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: expected allocations are queued when
// alloc is driven and popped as the DUT presents them.
module tb_phys_free_list;
    import phys_free_list_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   exp_q[$];

    phys_free_list_if bus ();

    phys_free_list dut (
        .clk   (clk),
        .reset (reset),
        .fl    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop(input string tag, input int obs);
        int e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d expected <empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.alloc_req    = 1'b0;
        bus.stall        = 1'b0;
        bus.retire_valid = 1'b0;
        bus.recover      = 1'b0;
        bus.retire_old_preg = '0;
        cyc();
        reset = 1'b0;
        exp_q.delete();
    endtask

    // Allocate n registers back to back, expecting first, first+1, ...
    task automatic alloc_n(input int n, input int first);
        for (int i = 0; i < n; i++) exp_q.push_back(first + i);
        bus.alloc_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk("alloc_valid", int'(bus.alloc_valid), 1);
            sb_pop("alloc_preg", int'(bus.alloc_preg));
            cyc();
        end
        bus.alloc_req = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.alloc_req = 1'b0;
        bus.stall = 1'b0;
        bus.retire_valid = 1'b0;
        bus.retire_old_preg = '0;
        bus.recover = 1'b0;

        // Reset state and exhaustion
        do_reset();
        chk("rst_count", int'(bus.count), 32);
        chk("rst_valid", int'(bus.alloc_valid), 1);
        chk("rst_preg", int'(bus.alloc_preg), 32);
        chk("rst_error", int'(bus.error), 0);
        alloc_n(32, 32);
        chk("empty_valid", int'(bus.alloc_valid), 0);
        chk("empty_count", int'(bus.count), 0);
        chk("empty_spec", int'(dut.spec_used_q), 32);

        // Refill from empty via retire
        bus.retire_valid = 1'b1;
        bus.retire_old_preg = 6'd2;
        chk("ret_same_valid", int'(bus.alloc_valid), 0);
        cyc();
        bus.retire_old_preg = 6'd3;
        chk("ret1_valid", int'(bus.alloc_valid), 1);
        chk("ret1_preg", int'(bus.alloc_preg), 2);
        chk("ret1_count", int'(bus.count), 1);
        cyc();
        bus.retire_valid = 1'b0;
        chk("ret2_count", int'(bus.count), 2);
        chk("ret2_commit", int'(dut.commit_head_q), 2);
        chk("ret2_spec", int'(dut.spec_used_q), 30);
        chk("ret2_error", int'(bus.error), 0);
        alloc_n(2, 2);
        chk("ret_drain_count", int'(bus.count), 0);

        // Recover alone
        do_reset();
        alloc_n(3, 32);
        chk("pre_rec_count", int'(bus.count), 29);
        bus.recover = 1'b1;
        cyc();
        bus.recover = 1'b0;
        chk("rec_count", int'(bus.count), 32);
        chk("rec_preg", int'(bus.alloc_preg), 32);
        chk("rec_head", int'(dut.head_q), 0);

        // Recover with a same-cycle retire
        do_reset();
        alloc_n(3, 32);
        bus.recover = 1'b1;
        bus.retire_valid = 1'b1;
        bus.retire_old_preg = 6'd7;
        cyc();
        bus.recover = 1'b0;
        bus.retire_valid = 1'b0;
        chk("recret_count", int'(bus.count), 32);
        chk("recret_commit", int'(dut.commit_head_q), 1);
        chk("recret_head", int'(dut.head_q), 1);
        chk("recret_preg", int'(bus.alloc_preg), 33);
        chk("recret_error", int'(bus.error), 0);
        chk("recret_spec", int'(dut.spec_used_q), 0);

        // Stall with retire into a full list
        do_reset();
        bus.stall = 1'b1;
        bus.alloc_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.retire_valid = (k == 1);
            bus.retire_old_preg = 6'd9;
            chk("stall_full_preg", int'(bus.alloc_preg), 32);
            cyc();
        end
        bus.retire_valid = 1'b0;
        bus.stall = 1'b0;
        bus.alloc_req = 1'b0;
        chk("stall_full_head", int'(dut.head_q), 0);
        chk("stall_full_count", int'(bus.count), 32);
        chk("stall_full_error", int'(bus.error), 1);

        // Stall with legal retire at count 31
        do_reset();
        alloc_n(1, 32);
        bus.stall = 1'b1;
        bus.alloc_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.retire_valid = (k == 2);
            bus.retire_old_preg = 6'd5;
            chk("stall_preg", int'(bus.alloc_preg), 33);
            cyc();
        end
        bus.retire_valid = 1'b0;
        bus.stall = 1'b0;
        bus.alloc_req = 1'b0;
        chk("stall_head", int'(dut.head_q), 1);
        chk("stall_count", int'(bus.count), 32);
        chk("stall_error", int'(bus.error), 0);
        chk("stall_commit", int'(dut.commit_head_q), 1);

        // Mid-stream reset clears state and sticky error
        do_reset();
        bus.retire_valid = 1'b1;
        bus.retire_old_preg = 6'd1;
        cyc();
        bus.retire_valid = 1'b0;
        chk("err_set", int'(bus.error), 1);
        alloc_n(10, 32);
        chk("mid_count", int'(bus.count), 22);
        bus.alloc_req = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        bus.alloc_req = 1'b0;
        chk("mid_rst_count", int'(bus.count), 32);
        chk("mid_rst_preg", int'(bus.alloc_preg), 32);
        chk("mid_rst_error", int'(bus.error), 0);
        chk("mid_rst_valid", int'(bus.alloc_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
